// File: rtl/freelist_ctrl_pkg.sv
// Shared types, sizes and helpers for the rename free list.
// FREELIST_BYPASS_EN (see freelist_ctrl) does not change anything in this package.
package freelist_ctrl_pkg;

  localparam int WAYS = 3;
  localparam int PRF = 64;
  localparam int ARCH_REGS = 32;
  localparam int PW = $clog2(PRF);

  typedef logic [PW-1:0]  preg_t;
  typedef logic [PRF-1:0] free_vec_t;

  // Pregs below ARCH_REGS hold the initial architectural mapping and start busy.
  function automatic free_vec_t free_reset_vec();
    free_vec_t v;
    v = '0;
    for (int i = 0; i < PRF; i++) begin
      v[i] = (i >= ARCH_REGS);
    end
    return v;
  endfunction

  function automatic logic [PW:0] free_count(input free_vec_t v);
    logic [PW:0] c;
    c = '0;
    for (int i = 0; i < PRF; i++) begin
      c = c + {{PW{1'b0}}, v[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/freelist_pick.sv
// Combinational grant picker: requesting ways, in ascending order, each take
// the lowest free preg left over by the earlier ways.
module freelist_pick
  import freelist_ctrl_pkg::*;
(
  input  free_vec_t               free_vec,
  input  logic [WAYS-1:0]         req,
  output logic [WAYS-1:0][PW-1:0] preg,
  output logic [WAYS-1:0]         valid
);

  // Returns {found, index} of the lowest set bit.
  function automatic logic [PW:0] find_first(input free_vec_t v);
    logic [PW:0] r;
    r = '0;
    for (int i = PRF - 1; i >= 0; i--) begin
      r = v[i] ? {1'b1, preg_t'(i)} : r;
    end
    return r;
  endfunction

  // Cascade of find-first stages, each stage masking the grant it makes.
  always_comb begin
    free_vec_t   mask;
    logic [PW:0] ff;
    mask  = free_vec;
    ff    = '0;
    preg  = '0;
    valid = '0;
    for (int k = 0; k < WAYS; k++) begin
      ff = find_first(mask);
      if (req[k] && ff[PW]) begin
        valid[k]         = 1'b1;
        preg[k]          = ff[PW-1:0];
        mask[ff[PW-1:0]] = 1'b0;
      end else begin
        valid[k] = 1'b0;
        preg[k]  = '0;
      end
    end
  end

endmodule

// File: rtl/freelist_ctrl.sv
// Physical-register free list for rename: speculative/architectural free vectors.
// Define FREELIST_BYPASS_EN to let pregs freed by retire be reused in the same cycle.
module freelist_ctrl
  import freelist_ctrl_pkg::*;
(
  input  logic                    clock,
  input  logic                    reset,
  input  logic [WAYS-1:0]         alloc_req,
  output logic [WAYS-1:0][PW-1:0] alloc_preg,
  output logic [WAYS-1:0]         alloc_valid,
  output logic                    alloc_stall,
  input  logic [WAYS-1:0]         retire_valid,
  input  logic [WAYS-1:0][PW-1:0] retire_told,
  input  logic [WAYS-1:0][PW-1:0] retire_tnew,
  input  logic                    squash,
  output logic [PW:0]             num_free
);

  free_vec_t spec_free_q, spec_free_d;
  free_vec_t arch_free_q, arch_free_d;
  free_vec_t freed_s, offer_vec_s;
  logic [PW:0] num_free_q, num_free_d;
  logic [WAYS-1:0][PW-1:0] pick_preg_s;
  logic [WAYS-1:0]         pick_valid_s;

  // Pregs released by this cycle's retire slots; p0 is never released.
  always_comb begin
    freed_s = '0;
    for (int k = 0; k < WAYS; k++) begin
      freed_s[retire_told[k]] = freed_s[retire_told[k]] |
                                (retire_valid[k] & (retire_told[k] != '0));
    end
  end

`ifdef FREELIST_BYPASS_EN
  assign offer_vec_s = squash ? spec_free_q : (spec_free_q | freed_s);
`else
  assign offer_vec_s = spec_free_q;
`endif

  freelist_pick u_pick (
    .free_vec (offer_vec_s),
    .req      (alloc_req),
    .preg     (pick_preg_s),
    .valid    (pick_valid_s)
  );

  assign alloc_valid = reset ? '0 : pick_valid_s;
  assign alloc_preg  = reset ? '0 : pick_preg_s;
  assign alloc_stall = ~reset & (|(alloc_req & ~pick_valid_s));
  assign num_free    = num_free_q;

  // Next state: retire first, then either squash restore or consume the grants.
  always_comb begin
    arch_free_d = arch_free_q;
    spec_free_d = spec_free_q | freed_s;
    for (int k = 0; k < WAYS; k++) begin
      arch_free_d[retire_told[k]] = arch_free_d[retire_told[k]] |
                                    (retire_valid[k] & (retire_told[k] != '0));
      arch_free_d[retire_tnew[k]] = arch_free_d[retire_tnew[k]] & ~retire_valid[k];
    end
    if (squash) begin
      spec_free_d = arch_free_d;
    end else begin
      for (int k = 0; k < WAYS; k++) begin
        spec_free_d[pick_preg_s[k]] = spec_free_d[pick_preg_s[k]] & ~pick_valid_s[k];
      end
    end
    num_free_d = free_count(spec_free_d);
  end

  // State registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      spec_free_q <= free_reset_vec();
      arch_free_q <= free_reset_vec();
      num_free_q  <= (PW+1)'(PRF - ARCH_REGS);
    end else begin
      spec_free_q <= spec_free_d;
      arch_free_q <= arch_free_d;
      num_free_q  <= num_free_d;
    end
  end

endmodule

// File: tb/tb_freelist_ctrl.sv
// Self-checking bench for freelist_ctrl: directed table, corner sequences and
// random traffic against a list-based reference model.
module tb_freelist_ctrl;
  import freelist_ctrl_pkg::*;

  logic clock = 1'b0;
  logic reset;
  logic [WAYS-1:0]         alloc_req, alloc_valid, retire_valid;
  logic [WAYS-1:0][PW-1:0] alloc_preg, retire_told, retire_tnew;
  logic                    alloc_stall, squash;
  logic [PW:0]             num_free;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  freelist_ctrl dut (
    .clock        (clock),
    .reset        (reset),
    .alloc_req    (alloc_req),
    .alloc_preg   (alloc_preg),
    .alloc_valid  (alloc_valid),
    .alloc_stall  (alloc_stall),
    .retire_valid (retire_valid),
    .retire_told  (retire_told),
    .retire_tnew  (retire_tnew),
    .squash       (squash),
    .num_free     (num_free)
  );

  // ---------------- reference model ----------------
  bit m_spec[PRF];
  bit m_arch[PRF];
  int m_num;
  int arch_map[ARCH_REGS];
  typedef struct { int areg; int preg; } inflight_t;
  inflight_t ifq[$];
  logic [WAYS-1:0][PW-1:0] m_ep;
  logic [WAYS-1:0]         m_ev;
  logic                    m_es;

  function automatic void m_reset();
    for (int i = 0; i < PRF; i++) begin
      m_spec[i] = (i >= ARCH_REGS);
      m_arch[i] = (i >= ARCH_REGS);
    end
    for (int r = 0; r < ARCH_REGS; r++) arch_map[r] = r;
    m_num = PRF - ARCH_REGS;
    ifq.delete();
  endfunction

  // Expected offer: list the available pregs in ascending order and deal them out.
  function automatic void m_offer();
    int avail[$];
    bit pool[PRF];
    m_ep = '0; m_ev = '0; m_es = 1'b0;
    if (reset) return;
    pool = m_spec;
`ifdef FREELIST_BYPASS_EN
    if (!squash)
      for (int k = 0; k < WAYS; k++)
        if (retire_valid[k] && retire_told[k] != 0) pool[retire_told[k]] = 1'b1;
`endif
    for (int i = 0; i < PRF; i++) if (pool[i]) avail.push_back(i);
    for (int k = 0; k < WAYS; k++) begin
      if (alloc_req[k]) begin
        if (avail.size() > 0) begin
          m_ep[k] = PW'(avail.pop_front());
          m_ev[k] = 1'b1;
        end else begin
          m_es = 1'b1;
        end
      end
    end
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic apply(input logic [WAYS-1:0] req, input logic [WAYS-1:0] rv,
                       input logic [WAYS-1:0][PW-1:0] told,
                       input logic [WAYS-1:0][PW-1:0] tnew,
                       input logic sq, input logic rst);
    alloc_req = req; retire_valid = rv; retire_told = told; retire_tnew = tnew;
    squash = sq; reset = rst;
    #1;
    m_offer();
    check("model_preg",  32'(alloc_preg),  32'(m_ep));
    check("model_valid", 32'(alloc_valid), 32'(m_ev));
    check("model_stall", 32'(alloc_stall), 32'(m_es));
    check("model_num",   32'(num_free),    32'(m_num));
  endtask

  task automatic advance();
    int cnt;
    @(posedge clock);
    if (reset) begin
      m_reset();
    end else begin
      for (int k = 0; k < WAYS; k++)
        if (retire_valid[k]) begin
          if (retire_told[k] != 0) begin
            m_arch[retire_told[k]] = 1'b1;
            m_spec[retire_told[k]] = 1'b1;
          end
          m_arch[retire_tnew[k]] = 1'b0;
        end
      if (squash) begin
        m_spec = m_arch;
        ifq.delete();
      end else begin
        for (int k = 0; k < WAYS; k++)
          if (m_ev[k]) begin
            m_spec[m_ep[k]] = 1'b0;
            ifq.push_back('{($urandom_range(0, 99) == 0) ? 0 : int'($urandom_range(1, ARCH_REGS - 1)),
                            int'(m_ep[k])});
          end
      end
      cnt = 0;
      for (int i = 0; i < PRF; i++) cnt += int'(m_spec[i]);
      m_num = cnt;
    end
    @(negedge clock);
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic [2:0]  req;
    logic        rv;
    logic [5:0]  told;
    logic [5:0]  tnew;
    logic        sq;
    logic [17:0] e_preg;
    logic [2:0]  e_valid;
    logic        e_stall;
    logic [6:0]  e_num;
  } vec_t;
  vec_t tbl[9];

  initial begin
    logic [WAYS-1:0]         rv;
    logic [WAYS-1:0][PW-1:0] told, tnew;
    logic [WAYS-1:0]         req;
    logic                    sq, rst;

    tbl[0] = '{3'b101, 1'b0, 6'd0,  6'd0,  1'b0, {6'd33, 6'd0,  6'd32}, 3'b101, 1'b0, 7'd32};
    tbl[1] = '{3'b111, 1'b0, 6'd0,  6'd0,  1'b0, {6'd36, 6'd35, 6'd34}, 3'b111, 1'b0, 7'd30};
    tbl[2] = '{3'b000, 1'b0, 6'd0,  6'd0,  1'b0, {6'd0,  6'd0,  6'd0},  3'b000, 1'b0, 7'd27};
    tbl[3] = '{3'b000, 1'b1, 6'd5,  6'd32, 1'b0, {6'd0,  6'd0,  6'd0},  3'b000, 1'b0, 7'd27};
    tbl[4] = '{3'b001, 1'b0, 6'd0,  6'd0,  1'b1, {6'd0,  6'd0,  6'd5},  3'b001, 1'b0, 7'd28};
    tbl[5] = '{3'b011, 1'b0, 6'd0,  6'd0,  1'b0, {6'd0,  6'd33, 6'd5},  3'b011, 1'b0, 7'd32};
    tbl[6] = '{3'b000, 1'b1, 6'd0,  6'd40, 1'b0, {6'd0,  6'd0,  6'd0},  3'b000, 1'b0, 7'd30};
    tbl[7] = '{3'b100, 1'b0, 6'd0,  6'd0,  1'b0, {6'd34, 6'd0,  6'd0},  3'b100, 1'b0, 7'd30};
    tbl[8] = '{3'b000, 1'b0, 6'd0,  6'd0,  1'b0, {6'd0,  6'd0,  6'd0},  3'b000, 1'b0, 7'd29};

    alloc_req = '0; retire_valid = '0; retire_told = '0; retire_tnew = '0;
    squash = 1'b0; reset = 1'b1;
    m_reset();
    repeat (2) @(posedge clock);
    @(negedge clock);

    // Reset holds the offer off even with every way requesting.
    apply(3'b111, '0, '0, '0, 1'b0, 1'b1);
    check("reset_valid", 32'(alloc_valid), 32'd0);
    check("reset_stall", 32'(alloc_stall), 32'd0);
    check("reset_num",   32'(num_free),    32'd32);
    advance();

    foreach (tbl[i]) begin
      apply(tbl[i].req, {2'b00, tbl[i].rv}, {12'd0, tbl[i].told}, {12'd0, tbl[i].tnew},
            tbl[i].sq, 1'b0);
      check($sformatf("tbl%0d_preg", i),  32'(alloc_preg),  32'(tbl[i].e_preg));
      check($sformatf("tbl%0d_valid", i), 32'(alloc_valid), 32'(tbl[i].e_valid));
      check($sformatf("tbl%0d_stall", i), 32'(alloc_stall), 32'(tbl[i].e_stall));
      check($sformatf("tbl%0d_num", i),   32'(num_free),    32'(tbl[i].e_num));
      advance();
    end

    // Drain the list down to a single free preg, then over-request.
    apply('0, '0, '0, '0, 1'b0, 1'b1);
    advance();
    for (int c = 0; c < 10; c++) begin
      apply(3'b111, '0, '0, '0, 1'b0, 1'b0);
      advance();
    end
    apply(3'b001, '0, '0, '0, 1'b0, 1'b0);
    advance();
    apply(3'b111, '0, '0, '0, 1'b0, 1'b0);
    check("drain_valid", 32'(alloc_valid), 32'b001);
    check("drain_stall", 32'(alloc_stall), 32'd1);
    check("drain_preg0", 32'(alloc_preg[0]), 32'd63);
    check("drain_num",   32'(num_free),    32'd1);
    advance();
    apply(3'b111, '0, '0, '0, 1'b0, 1'b0);
    check("empty_valid", 32'(alloc_valid), 32'd0);
    check("empty_stall", 32'(alloc_stall), 32'd1);
    check("empty_num",   32'(num_free),    32'd0);
    advance();

    // Empty list: retire frees p7 while way0 requests in the same cycle.
    told = '0; tnew = '0; told[0] = PW'(7); tnew[0] = PW'(33);
    apply(3'b001, 3'b001, told, tnew, 1'b0, 1'b0);
`ifdef FREELIST_BYPASS_EN
    check("byp_same_valid", 32'(alloc_valid), 32'b001);
    check("byp_same_preg",  32'(alloc_preg[0]), 32'd7);
    check("byp_same_stall", 32'(alloc_stall), 32'd0);
`else
    check("byp_same_valid", 32'(alloc_valid), 32'd0);
    check("byp_same_stall", 32'(alloc_stall), 32'd1);
`endif
    advance();
    apply(3'b001, '0, '0, '0, 1'b0, 1'b0);
`ifdef FREELIST_BYPASS_EN
    check("byp_next_valid", 32'(alloc_valid), 32'd0);
    check("byp_next_stall", 32'(alloc_stall), 32'd1);
    check("byp_next_num",   32'(num_free),    32'd0);
`else
    check("byp_next_valid", 32'(alloc_valid), 32'b001);
    check("byp_next_preg",  32'(alloc_preg[0]), 32'd7);
    check("byp_next_num",   32'(num_free),    32'd1);
`endif
    advance();

    // Random traffic with legal retires drawn from the in-flight list.
    apply('0, '0, '0, '0, 1'b0, 1'b1);
    advance();
    for (int c = 0; c < 1500; c++) begin
      bit [ARCH_REGS-1:0] used;
      int nret;
      rst  = ($urandom_range(0, 199) == 0);
      sq   = ($urandom_range(0, 29) == 0);
      req  = WAYS'($urandom);
      rv   = '0; told = '0; tnew = '0; used = '0;
      nret = $urandom_range(0, WAYS);
      for (int k = 0; k < nret; k++) begin
        if (ifq.size() > 0 && !used[ifq[0].areg]) begin
          inflight_t e;
          e = ifq.pop_front();
          used[e.areg] = 1'b1;
          rv[k]   = 1'b1;
          told[k] = PW'(arch_map[e.areg]);
          tnew[k] = PW'(e.preg);
          if (e.areg != 0) arch_map[e.areg] = e.preg;
        end
      end
      apply(req, rv, told, tnew, sq, rst);
      advance();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
